// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register map, trigger
// encodings and FSM state type.
package irq_ctrl_pkg;

  localparam logic [1:0] IRQ_ADDR_TRIG    = 2'd0;
  localparam logic [1:0] IRQ_ADDR_ENABLE  = 2'd1;
  localparam logic [1:0] IRQ_ADDR_PENDING = 2'd2;
  localparam logic [1:0] IRQ_ADDR_INSERV  = 2'd3;

  localparam logic IRQ_TRIG_LEVEL = 1'b0;
  localparam logic IRQ_TRIG_EDGE  = 1'b1;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    IRQ_ST_IDLE    = 2'd0,
    IRQ_ST_REQ     = 2'd1,
    IRQ_ST_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_sync.sv
// Single-bit 2-flop synchroniser with a trailing delay flop for edge detect.
module irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  logic s1, s2, s3;

  // s1/s2 resolve metastability; s3 is the previous s2 for rise detection
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises sources, latches pending bits, picks
// the lowest-index enabled candidate and runs one request at a time through
// REQ -> SERVICE -> IDLE.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int IRQ_CH = 8,
  parameter int VEC_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IRQ_CH-1:0] irq_src,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [IRQ_CH-1:0] cfg_wdata,
  output logic [IRQ_CH-1:0] cfg_rdata,
  input  logic              int_ack,
  input  logic              int_eoi,
  output logic [IRQ_CH-1:0] irq,
  output logic [VEC_W-1:0]  int_vec,
  output logic              int_busy
);

  localparam logic [IRQ_CH-1:0] ONE = {{(IRQ_CH-1){1'b0}}, 1'b1};

  irq_state_e        state, state_n;
  logic [IRQ_CH-1:0] trig, enable, pending, inserv;
  logic [IRQ_CH-1:0] lvl, rise, cand, pending_n, w1c, ack_clr, vec_oh;
  logic [IRQ_CH-1:0] irq_n;
  logic [VEC_W-1:0]  vec_n, sel_idx;
  logic              sel_vld, ack_take, eoi_take;

  for (genvar g = 0; g < IRQ_CH; g++) begin : g_sync
    irq_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (irq_src[g]),
      .level (lvl[g]),
      .rise  (rise[g])
    );
  end

  assign cand     = pending & enable & ~inserv;
  assign vec_oh   = ONE << int_vec;
  assign int_busy = (state != IRQ_ST_IDLE);

  // lowest index wins: scan downward so the last hit is the smallest index
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = IRQ_CH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel_vld = 1'b1;
        sel_idx = VEC_W'(i);
      end
    end
  end

  // next-state and registered-output values for the request FSM
  always_comb begin
    state_n  = state;
    irq_n    = irq;
    vec_n    = int_vec;
    ack_take = 1'b0;
    eoi_take = 1'b0;
    case (state)
      IRQ_ST_IDLE: begin
        if (sel_vld) begin
          state_n = IRQ_ST_REQ;
          vec_n   = sel_idx;
          irq_n   = ONE << sel_idx;
        end
      end
      IRQ_ST_REQ: begin
        // ack beats a simultaneous withdrawal
        if (int_ack) begin
          ack_take = 1'b1;
          irq_n    = '0;
          state_n  = IRQ_ST_SERVICE;
        end else if (!(pending[int_vec] && enable[int_vec])) begin
          irq_n   = '0;
          state_n = IRQ_ST_IDLE;
        end
      end
      IRQ_ST_SERVICE: begin
        if (int_eoi) begin
          eoi_take = 1'b1;
          state_n  = IRQ_ST_IDLE;
        end
      end
      default: begin
        state_n = IRQ_ST_IDLE;
        irq_n   = '0;
      end
    endcase
  end

  // pending: level channels follow s2; edge channels set on rise, clear on
  // ack or W1C, with set winning a same-cycle race
  always_comb begin
    w1c     = (cfg_we && cfg_addr == IRQ_ADDR_PENDING) ? cfg_wdata : '0;
    ack_clr = ack_take ? vec_oh : '0;
    pending_n = '0;
    for (int i = 0; i < IRQ_CH; i++) begin
      if (trig[i] == IRQ_TRIG_EDGE)
        pending_n[i] = rise[i] | (pending[i] & ~(w1c[i] | ack_clr[i]));
      else
        pending_n[i] = lvl[i];
    end
  end

  // state, outputs and configuration registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IRQ_ST_IDLE;
      irq     <= '0;
      int_vec <= '0;
      trig    <= '0;
      enable  <= '0;
      pending <= '0;
      inserv  <= '0;
    end else begin
      state   <= state_n;
      irq     <= irq_n;
      int_vec <= vec_n;
      pending <= pending_n;
      if (cfg_we && cfg_addr == IRQ_ADDR_TRIG)   trig   <= cfg_wdata;
      if (cfg_we && cfg_addr == IRQ_ADDR_ENABLE) enable <= cfg_wdata;
      if (ack_take)      inserv <= vec_oh;
      else if (eoi_take) inserv <= '0;
    end
  end

  // combinational register read
  always_comb begin
    case (cfg_addr)
      IRQ_ADDR_TRIG:    cfg_rdata = trig;
      IRQ_ADDR_ENABLE:  cfg_rdata = enable;
      IRQ_ADDR_PENDING: cfg_rdata = pending;
      default:          cfg_rdata = inserv;
    endcase
  end

endmodule
